// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions used by the fetch path: data width, boot vector
// and the packed {pc, instr} entry carried through the fetch queue.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC00000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic DEPTH-entry synchronous FIFO with flush; the head is read
// combinationally so a pushed entry is visible one cycle after the push.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW-1:0]    wr_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   // A push into a full queue is only legal when the head leaves this cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wr_ptr_reg] <= push_data;
   end

   assign head  = mem[rd_ptr_reg];
   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register feeding a small queue toward decode, with
// redirect flush. Define FETCH_PERF_EN to add perf_fetched/perf_stall counters.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_plus4
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall
`endif
);

   logic [XLEN-1:0]            pc_reg;
   logic [XLEN-1:0]            pc_next;
   logic                       q_empty;
   logic                       q_full;
   logic                       pop;
   logic                       push;
   logic [$bits(fetch_entry_t)-1:0] head_bits;
   fetch_entry_t               head_entry;
   fetch_entry_t               push_entry;

   assign pop  = out_valid && out_ready;
   assign push = (!q_full || pop) && !redirect_valid;

   assign imem_addr  = word_align(pc_reg);
   assign push_entry = '{pc: imem_addr, instr: imem_data};

   always_comb begin
      pc_next = pc_reg;
      if (redirect_valid)
         pc_next = word_align(redirect_pc);
      else if (push)
         pc_next = pc_reg + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) pc_reg <= RESET_PC;
      else     pc_reg <= pc_next;
   end

   fetch_queue #(
      .DEPTH (QDEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head_bits),
      .empty     (q_empty),
      .full      (q_full)
   );

   assign head_entry   = head_bits;
   assign out_valid    = !q_empty;
   assign out_instr    = head_entry.instr;
   assign out_pc       = head_entry.pc;
   assign out_pc_plus4 = head_entry.pc + 32'd4;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_reg;
   logic [31:0] perf_stall_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_reg <= '0;
         perf_stall_reg   <= '0;
      end else begin
         if (push)                   perf_fetched_reg <= perf_fetched_reg + 32'd1;
         if (out_valid && !out_ready) perf_stall_reg  <= perf_stall_reg + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_reg;
   assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default QDEPTH=2); the
// counter scenario is compiled in only when FETCH_PERF_EN is defined.
module tb_fetch_unit;

   localparam logic [31:0] IKEY = 32'h5A5AF00F;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus4;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Instruction memory model: word content derived from its address.
   assign imem_data = imem_addr ^ IKEY;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (imem_addr !== 32'hBFC00000) begin
         n_bad++;
         $display("FAIL reset_imem_addr: got %h want %h", imem_addr, 32'hBFC00000);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'hBFC00000) begin
         n_bad++;
         $display("FAIL reset_first_fetch: valid %b pc %h want 1 %h", out_valid, out_pc, 32'hBFC00000);
      end
   endtask

   task automatic test_streaming();
      logic [31:0] exp_pc;
      do_reset();
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'hBFC00000 + 32'(4 * i);
         $display("stream pop %0d: pc %h instr %h", i, out_pc, out_instr);
         n_cmp++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
            n_bad++;
            $display("FAIL stream_pc[%0d]: valid %b pc %h want 1 %h", i, out_valid, out_pc, exp_pc);
         end
         n_cmp++;
         if (out_instr !== (exp_pc ^ IKEY)) begin
            n_bad++;
            $display("FAIL stream_instr[%0d]: got %h want %h", i, out_instr, exp_pc ^ IKEY);
         end
         n_cmp++;
         if (out_pc_plus4 !== exp_pc + 32'd4) begin
            n_bad++;
            $display("FAIL stream_pc_plus4[%0d]: got %h want %h", i, out_pc_plus4, exp_pc + 32'd4);
         end
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc;
      do_reset();
      for (int i = 0; i < 5; i++) tick();
      n_cmp++;
      if (imem_addr !== 32'hBFC00008) begin
         n_bad++;
         $display("FAIL bp_pc_hold: got %h want %h", imem_addr, 32'hBFC00008);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'hBFC00000 || out_instr !== (32'hBFC00000 ^ IKEY)) begin
         n_bad++;
         $display("FAIL bp_head_hold: valid %b pc %h instr %h want 1 %h %h",
                  out_valid, out_pc, out_instr, 32'hBFC00000, 32'hBFC00000 ^ IKEY);
      end
      tick();
      n_cmp++;
      if (imem_addr !== 32'hBFC00008 || out_pc !== 32'hBFC00000) begin
         n_bad++;
         $display("FAIL bp_still_hold: addr %h pc %h want %h %h", imem_addr, out_pc, 32'hBFC00008, 32'hBFC00000);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_pc = 32'hBFC00000 + 32'(4 * i);
         $display("bp resume pop %0d: pc %h", i, out_pc);
         n_cmp++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
            n_bad++;
            $display("FAIL bp_resume[%0d]: valid %b pc %h want 1 %h", i, out_valid, out_pc, exp_pc);
         end
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_redirect();
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'hBFC00102;
      tick();
      redirect_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL redir_flush_valid: got %b want 0", out_valid);
      end
      n_cmp++;
      if (imem_addr !== 32'hBFC00100) begin
         n_bad++;
         $display("FAIL redir_imem_addr: got %h want %h", imem_addr, 32'hBFC00100);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'hBFC00100) begin
         n_bad++;
         $display("FAIL redir_target: valid %b pc %h want 1 %h", out_valid, out_pc, 32'hBFC00100);
      end
      // Redirect coinciding with a pop still flushes the queue.
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h00001000;
      tick();
      redirect_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || imem_addr !== 32'h00001000) begin
         n_bad++;
         $display("FAIL redir_with_pop: valid %b addr %h want 0 %h", out_valid, imem_addr, 32'h00001000);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      out_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFFFFFC;
      tick();
      redirect_valid = 1'b0;
      n_cmp++;
      if (imem_addr !== 32'hFFFFFFFC) begin
         n_bad++;
         $display("FAIL wrap_imem_addr: got %h want %h", imem_addr, 32'hFFFFFFFC);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'hFFFFFFFC) begin
         n_bad++;
         $display("FAIL wrap_first_pc: valid %b pc %h want 1 %h", out_valid, out_pc, 32'hFFFFFFFC);
      end
      n_cmp++;
      if (out_pc_plus4 !== 32'h00000000) begin
         n_bad++;
         $display("FAIL wrap_pc_plus4: got %h want %h", out_pc_plus4, 32'h00000000);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h00000000 || out_instr !== IKEY) begin
         n_bad++;
         $display("FAIL wrap_second_pc: valid %b pc %h instr %h want 1 %h %h",
                  out_valid, out_pc, out_instr, 32'h00000000, IKEY);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      // Reset must win over a simultaneous redirect and drop queued entries.
      rst = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'hBFC00102;
      tick();
      rst = 1'b0;
      redirect_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || imem_addr !== 32'hBFC00000) begin
         n_bad++;
         $display("FAIL mid_reset: valid %b addr %h want 0 %h", out_valid, imem_addr, 32'hBFC00000);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'hBFC00000) begin
         n_bad++;
         $display("FAIL mid_reset_refetch: valid %b pc %h want 1 %h", out_valid, out_pc, 32'hBFC00000);
      end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      do_reset();
      tick();             // push, queue was empty
      tick();             // push, stall
      tick();             // full, stall
      out_ready = 1'b1;
      tick();             // pop + push
      out_ready = 1'b0;
      n_cmp++;
      if (perf_fetched !== 32'd3) begin
         n_bad++;
         $display("FAIL perf_fetched: got %0d want 3", perf_fetched);
      end
      n_cmp++;
      if (perf_stall !== 32'd2) begin
         n_bad++;
         $display("FAIL perf_stall: got %0d want 2", perf_stall);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
         n_bad++;
         $display("FAIL perf_reset: fetched %0d stall %0d want 0 0", perf_fetched, perf_stall);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_mid_reset();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
